// File: rtl/y_fetch_ctrl.sv
// y_fetch_ctrl: sequences row-pointer and dual-port data reads of the Y sparse-matrix SRAM
module y_fetch_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256,
  parameter int SRAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_row,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr1,
  output logic [ADDR_W-1:0] sram_addr2,
  input  logic [DATA_W-1:0] sram_rdata1,
  input  logic [DATA_W-1:0] sram_rdata2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [ADDR_W-1:0] rsp_addr1,
  output logic              rsp_err
);
  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_WAIT, DAT_RD, DAT_WAIT, RESP} state_t;
  localparam logic [1:0] LAST = 2'(SRAM_LAT - 1);
  state_t state, next_state;
  logic [1:0] cnt;
  logic [1:0] mode;
  logic [ADDR_W-1:0] row_q, a1_q, a2_q;
  logic [15:0] ptr;
  logic accept, done, empty, row_mode, illegal, wait_st;
  assign mode = {|req_addr1, |req_addr2};
  assign row_mode = mode == 2'b00;
  assign illegal = mode == 2'b01;
  assign accept = req_valid && req_ready;
  assign wait_st = state == PTR_WAIT || state == DAT_WAIT;
  assign done = cnt == LAST;
  assign ptr = sram_rdata1[16*row_q[3:0] +: 16];
  assign empty = ptr == 16'hFFFF;
  assign rsp_addr1 = a1_q;
  always_ff @(posedge clock)
    state <= !reset ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = illegal ? RESP : row_mode ? PTR_RD : DAT_RD;
      PTR_RD:   next_state = PTR_WAIT;
      PTR_WAIT: if (done) next_state = empty ? RESP : DAT_RD;
      DAT_RD:   next_state = DAT_WAIT;
      DAT_WAIT: if (done) next_state = RESP;
      RESP:     if (rsp_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    sram_rd_en = state == PTR_RD || state == DAT_RD;
    sram_addr1 = (state == PTR_RD || state == PTR_WAIT) ? row_q >> 4 :
                 (state == DAT_RD || state == DAT_WAIT) ? a1_q : '0;
    sram_addr2 = (state == DAT_RD || state == DAT_WAIT) ? a2_q : '0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      row_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      cnt <= '0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= (wait_st && !done) ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        row_q <= req_row;
        a1_q <= illegal ? '0 : row_mode ? a1_q : req_addr1;
        a2_q <= |req_addr2 ? req_addr2 : req_addr1 + ADDR_W'(1);
        rsp_data1 <= '0;
        rsp_data2 <= '0;
        rsp_err <= illegal;
      end
      if (state == PTR_WAIT && done) begin
        rsp_err <= empty;
        if (!empty) begin
          a1_q <= ptr[ADDR_W-1:0];
          a2_q <= ptr[ADDR_W-1:0] + ADDR_W'(1);
        end
      end
      if (state == DAT_WAIT && done) begin
        rsp_data1 <= sram_rdata1;
        rsp_data2 <= sram_rdata2;
      end
    end
  end
endmodule

// File: tb/tb_y_fetch_ctrl.sv
// tb_y_fetch_ctrl: directed self-checking bench for y_fetch_ctrl at SRAM latency 1 and 3
module tb_y_fetch_ctrl;
  logic clock, reset;
  logic req_valid, req_ready, rsp_valid, rsp_ready, sram_rd_en, rsp_err;
  logic [10:0] req_row, req_addr1, req_addr2, sram_addr1, sram_addr2, rsp_addr1;
  logic [255:0] sram_rdata1, sram_rdata2, rsp_data1, rsp_data2;
  logic req_valid3, req_ready3, rsp_valid3, rd_en3, rsp_err3;
  logic rsp_ready3 = 1'b1;
  logic [10:0] a13, a23, rsp_a13;
  logic [255:0] rd13, rd23, rsp_d13, rsp_d23;
  logic pv = 1'b0;
  logic [10:0] pa1, pa2;
  logic [2:0] pv3 = '0;
  logic [2:0][10:0] pa13, pa23;
  int n_checks = 0, n_fails = 0, rd_cnt = 0, rsp_cnt = 0;
  int r0, s0;
  localparam logic [255:0] JUNK = {8{32'hDEADBEEF}};

  y_fetch_ctrl #(.ADDR_W(11), .DATA_W(256), .SRAM_LAT(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .sram_rd_en(sram_rd_en), .sram_addr1(sram_addr1), .sram_addr2(sram_addr2),
    .sram_rdata1(sram_rdata1), .sram_rdata2(sram_rdata2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(rsp_data1),
    .rsp_data2(rsp_data2), .rsp_addr1(rsp_addr1), .rsp_err(rsp_err));

  y_fetch_ctrl #(.ADDR_W(11), .DATA_W(256), .SRAM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_row(req_row), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .sram_rd_en(rd_en3), .sram_addr1(a13), .sram_addr2(a23),
    .sram_rdata1(rd13), .sram_rdata2(rd23),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data1(rsp_d13),
    .rsp_data2(rsp_d23), .rsp_addr1(rsp_a13), .rsp_err(rsp_err3));

  function automatic logic [255:0] sram_word(input logic [10:0] a);
    logic [255:0] w;
    w = {8{21'h15A5A, a}};
    if (a == 11'h002)
      for (int i = 0; i < 16; i++) w[16*i +: 16] = (i == 3) ? 16'h0150 : 16'h0100 + 16'(i);
    if (a == 11'h005) w[16*7 +: 16] = 16'hFFFF;
    return w;
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    pv <= sram_rd_en;
    pa1 <= sram_addr1;
    pa2 <= sram_addr2;
    pv3 <= {pv3[1:0], rd_en3};
    pa13 <= {pa13[1:0], a13};
    pa23 <= {pa23[1:0], a23};
    if (sram_rd_en) rd_cnt <= rd_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  assign sram_rdata1 = pv ? sram_word(pa1) : JUNK;
  assign sram_rdata2 = pv ? sram_word(pa2) : JUNK;
  assign rd13 = pv3[2] ? sram_word(pa13[2]) : JUNK;
  assign rd23 = pv3[2] ? sram_word(pa23[2]) : JUNK;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, req_ready, 1'b1);
    check({tag, "_rden"}, sram_rd_en, 1'b0);
    check({tag, "_saddr"}, {sram_addr1, sram_addr2}, 22'h0);
    check({tag, "_valid"}, rsp_valid, 1'b0);
    check({tag, "_err"}, rsp_err, 1'b0);
    check({tag, "_data"}, rsp_data1 | rsp_data2, 256'h0);
    check({tag, "_raddr"}, rsp_addr1, 11'h0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_valid3 = 1'b0;
    rsp_ready = 1'b1;
    req_row = '0;
    req_addr1 = '0;
    req_addr2 = '0;
    repeat (3) tick();
    check_reset_state("rst");
    check("rst_ready3", {req_ready3, rd_en3, rsp_valid3}, 3'b100);
    reset = 1'b1;
    tick();

    req_row = 11'h023;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_row = 11'h7FF;
    check("row_ptr_en", sram_rd_en, 1'b1);
    check("row_ptr_addr", {sram_addr1, sram_addr2}, {11'h002, 11'h000});
    check("row_busy", req_ready, 1'b0);
    tick();
    check("row_gap", sram_rd_en, 1'b0);
    tick();
    check("row_dat_en", sram_rd_en, 1'b1);
    check("row_dat_addr", {sram_addr1, sram_addr2}, {11'h150, 11'h151});
    tick();
    check("row_wait", {sram_rd_en, rsp_valid}, 2'b00);
    tick();
    check("row_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("row_d1", rsp_data1, sram_word(11'h150));
    check("row_d2", rsp_data2, sram_word(11'h151));
    check("row_raddr", rsp_addr1, 11'h150);
    check("row_saddr_idle", {sram_addr1, sram_addr2}, 22'h0);
    tick();
    check("row_done", {req_ready, rsp_valid}, 2'b10);

    req_addr1 = 11'h010;
    req_addr2 = 11'h040;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("dir_en", sram_rd_en, 1'b1);
    check("dir_addr", {sram_addr1, sram_addr2}, {11'h010, 11'h040});
    tick();
    check("dir_wait", {sram_rd_en, rsp_valid}, 2'b00);
    tick();
    check("dir_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("dir_d1", rsp_data1, sram_word(11'h010));
    check("dir_d2", rsp_data2, sram_word(11'h040));
    tick();

    req_addr1 = 11'h7FF;
    req_addr2 = 11'h000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("half_addr", {sram_rd_en, sram_addr1, sram_addr2}, {1'b1, 11'h7FF, 11'h000});
    tick();
    tick();
    check("half_rsp", {rsp_valid, rsp_err, rsp_addr1}, {2'b10, 11'h7FF});
    check("half_d2", rsp_data2, sram_word(11'h000));
    tick();

    r0 = rd_cnt;
    req_addr1 = 11'h000;
    req_addr2 = 11'h005;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ill_rsp", {rsp_valid, rsp_err, sram_rd_en}, 3'b110);
    check("ill_data", rsp_data1 | rsp_data2, 256'h0);
    check("ill_raddr", rsp_addr1, 11'h0);
    tick();
    check("ill_rdcnt", rd_cnt - r0, 0);

    r0 = rd_cnt;
    req_addr2 = 11'h000;
    req_row = 11'h057;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("emp_ptr", {sram_rd_en, sram_addr1}, {1'b1, 11'h005});
    tick();
    check("emp_wait", rsp_valid, 1'b0);
    tick();
    check("emp_rsp", {rsp_valid, rsp_err, sram_rd_en}, 3'b110);
    check("emp_data", rsp_data1 | rsp_data2, 256'h0);
    check("emp_rdcnt", rd_cnt - r0, 1);
    tick();

    rsp_ready = 1'b0;
    req_addr1 = 11'h010;
    req_addr2 = 11'h040;
    req_valid = 1'b1;
    tick();
    req_addr1 = 11'h020;
    req_addr2 = 11'h030;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {rsp_valid, req_ready, rsp_err, rsp_addr1}, {3'b100, 11'h010});
      check("bp_data", rsp_data1 ^ rsp_data2, sram_word(11'h010) ^ sram_word(11'h040));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_released", {req_ready, rsp_valid}, 2'b10);
    tick();
    req_valid = 1'b0;
    check("bp_next", {sram_rd_en, sram_addr1, sram_addr2}, {1'b1, 11'h020, 11'h030});
    tick();
    tick();
    check("bp_next_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("bp_next_d1", rsp_data1, sram_word(11'h020));
    tick();

    s0 = rsp_cnt;
    req_addr1 = 11'h000;
    req_addr2 = 11'h000;
    req_row = 11'h023;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_ptr_en", sram_rd_en, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    check_reset_state("mid");
    reset = 1'b1;
    repeat (8) tick();
    check("mid_no_rsp", rsp_cnt - s0, 0);
    check("mid_idle", {req_ready, rsp_valid}, 2'b10);

    req_row = 11'h023;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("l3_en_%0d", k), rd_en3, 1'(k == 1 || k == 5));
      check($sformatf("l3_valid_%0d", k), rsp_valid3, 1'(k == 9));
      if (k == 5) check("l3_dat_addr", {a13, a23}, {11'h150, 11'h151});
      if (k == 9) begin
        check("l3_err", {rsp_err3, rsp_a13}, {1'b0, 11'h150});
        check("l3_d1", rsp_d13, sram_word(11'h150));
        check("l3_d2", rsp_d23, sram_word(11'h151));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
